// File: rtl/acc_vec_pkg.sv
// Shared types for the vector accumulate engine: operation modes and control FSM states.
package acc_vec_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_MUL = 2'd2,
    MODE_DOT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // ADD and SUB are the only modes that honour the saturation flag.
  function automatic logic mode_saturates(input mode_e mode);
    return (mode == MODE_ADD) || (mode == MODE_SUB);
  endfunction

endpackage

// File: rtl/acc_vec_lane.sv
// One registered lane ALU: wrapping or saturating add/sub, low-half signed multiply.
module acc_vec_lane
  import acc_vec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  mode_e                 mode,
  input  logic                  sat,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res
);

  localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0]   a_ext;
  logic [DATA_WIDTH:0]   b_ext;
  logic [DATA_WIDTH:0]   sum_ext;
  logic [DATA_WIDTH-1:0] prod_lo;
  logic [DATA_WIDTH-1:0] res_d;

  // One guard bit: the two top bits differ exactly when the signed result overflowed.
  assign a_ext   = {a[DATA_WIDTH-1], a};
  assign b_ext   = {b[DATA_WIDTH-1], b};
  assign sum_ext = (mode == MODE_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
  // The low half of a product is identical for signed and unsigned operands.
  assign prod_lo = a * b;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    res_d = prod_lo;
    if (mode_saturates(mode)) begin
      res_d = sum_ext[DATA_WIDTH-1:0];
      if (sat && (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1])) begin
        res_d = sum_ext[DATA_WIDTH] ? SMIN : SMAX;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res <= '0;
    end else if (en) begin
      res <= res_d;
    end
  end

endmodule

// File: rtl/acc_vec_engine.sv
// Vector engine: streams operand beats through LANES lane ALUs, writes results or reduces to a dot product.
module acc_vec_engine
  import acc_vec_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 256,
  parameter  int LANES      = 1,
  localparam int BEATS      = DEPTH / LANES,
  localparam int AW         = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LW         = $clog2(BEATS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [1:0]                  mode_i,
  input  logic                        sat_i,
  input  logic [LW-1:0]               len_i,
  output logic                        rd_en_o,
  output logic [AW-1:0]               rd_addr_o,
  input  logic [LANES*DATA_WIDTH-1:0] a_rdata_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_rdata_i,
  output logic                        wr_en_o,
  output logic [AW-1:0]               wr_addr_o,
  output logic [LANES*DATA_WIDTH-1:0] wr_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [DATA_WIDTH-1:0]       dot_o
);

  localparam logic [LW-1:0] BEATS_L = LW'(BEATS);

  state_e                      state, state_nx;
  mode_e                       mode_q;
  logic                        sat_q;
  logic [LW-1:0]               len_q;
  logic [LW-1:0]               len_eff;
  logic [AW-1:0]               addr_q;
  logic                        drain_q;
  logic                        start_ok;
  logic                        last_rd;

  // Two-stage shadow of each read: stage 1 = operands on the bus, stage 2 = lane result registered.
  logic                        v1, v2;
  logic                        l1, l2;
  logic [AW-1:0]               a1, a2;

  logic [LANES*DATA_WIDTH-1:0] lane_res;
  logic [DATA_WIDTH-1:0]       lane_sum;
  logic [DATA_WIDTH-1:0]       acc_q;
  logic [DATA_WIDTH-1:0]       dot_q;

  assign len_eff  = (len_i > BEATS_L) ? BEATS_L : len_i;
  assign start_ok = (state == ST_IDLE) && start_i && !abort_i;
  assign last_rd  = (LW'(addr_q) == (len_q - LW'(1)));

  always_comb begin
    state_nx = state;
    rd_en_o  = 1'b0;
    done_o   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) state_nx = (len_eff == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (abort_i) begin
          state_nx = ST_IDLE;
        end else begin
          rd_en_o = 1'b1;
          if (last_rd) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort_i)      state_nx = ST_IDLE;
        else if (drain_q) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        done_o   = !abort_i;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  assign busy_o    = (state != ST_IDLE);
  assign rd_addr_o = addr_q;
  assign wr_en_o   = v2 && (mode_q != MODE_DOT) && !abort_i;
  assign wr_addr_o = a2;
  assign wr_data_o = lane_res;
  assign dot_o     = dot_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    acc_vec_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (v1),
      .mode (mode_q),
      .sat  (sat_q),
      .a    (a_rdata_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .b    (b_rdata_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .res  (lane_res[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + lane_res[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_ADD;
      sat_q   <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      drain_q <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      l1      <= 1'b0;
      l2      <= 1'b0;
      a1      <= '0;
      a2      <= '0;
      acc_q   <= '0;
      dot_q   <= '0;
    end else begin
      // An abort kills anything still in flight so it never reaches the write port or the accumulator.
      v1 <= rd_en_o;
      l1 <= rd_en_o && last_rd;
      a1 <= addr_q;
      v2 <= v1 && !abort_i;
      l2 <= l1 && !abort_i;
      a2 <= a1;

      if (start_ok) begin
        mode_q  <= mode_e'(mode_i);
        sat_q   <= sat_i;
        len_q   <= len_eff;
        addr_q  <= '0;
        drain_q <= 1'b0;
        acc_q   <= '0;
        dot_q   <= '0;
      end

      if (rd_en_o) addr_q <= addr_q + AW'(1);
      if (state == ST_DRAIN) drain_q <= !drain_q;

      if (v2 && !abort_i && (mode_q == MODE_DOT)) begin
        acc_q <= acc_q + lane_sum;
        if (l2) dot_q <= acc_q + lane_sum;
      end
    end
  end

endmodule

// File: tb/tb_acc_vec_engine.sv
// Randomised self-checking bench for acc_vec_engine against a plain-arithmetic reference model.
module tb_acc_vec_engine;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int LANES = 4;
  localparam int BEATS = DEPTH / LANES;
  localparam int AW    = 3;
  localparam int LW    = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_i, abort_i, sat_i;
  logic [1:0]            mode_i;
  logic [LW-1:0]         len_i;
  logic                  rd_en_o, wr_en_o, busy_o, done_o;
  logic [AW-1:0]         rd_addr_o, wr_addr_o;
  logic [LANES*DW-1:0]   a_rdata_i, b_rdata_i, wr_data_o;
  logic [DW-1:0]         dot_o;

  logic [LANES*DW-1:0]   a_mem [BEATS];
  logic [LANES*DW-1:0]   b_mem [BEATS];
  logic [LANES*DW-1:0]   got   [BEATS];

  int n_checks = 0;
  int n_errors = 0;

  acc_vec_engine #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .LANES     (LANES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .mode_i    (mode_i),
    .sat_i     (sat_i),
    .len_i     (len_i),
    .rd_en_o   (rd_en_o),
    .rd_addr_o (rd_addr_o),
    .a_rdata_i (a_rdata_i),
    .b_rdata_i (b_rdata_i),
    .wr_en_o   (wr_en_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .dot_o     (dot_o)
  );

  always #5 clk = ~clk;

  // Operand buffers: synchronous read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en_o) begin
      a_rdata_i <= a_mem[rd_addr_o];
      b_rdata_i <= b_mem[rd_addr_o];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_model(input int mode, input bit sat,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    case (mode)
      0:       r = sa + sb;
      1:       r = sa - sb;
      default: r = sa * sb;
    endcase
    if (mode < 2 && sat) begin
      if (r > SMAX)      r = SMAX;
      else if (r < SMIN) r = SMIN;
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick_value();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
      2:       return 32'h8000_0000 + 32'($urandom_range(0, 31));
      default: return 32'($urandom_range(0, 100)) - 32'd50;
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < BEATS; i++)
      for (int l = 0; l < LANES; l++) begin
        a_mem[i][l*DW +: DW] = pick_value();
        b_mem[i][l*DW +: DW] = pick_value();
      end
  endtask

  task automatic fill_const(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < BEATS; i++)
      for (int l = 0; l < LANES; l++) begin
        a_mem[i][l*DW +: DW] = a;
        b_mem[i][l*DW +: DW] = b;
      end
  endtask

  // abort_k > 0 raises abort_i in that cycle after acceptance; poke pulses start_i and scrambles config mid-run.
  task automatic run_op(input int mode, input bit sat, input int len, input int abort_k,
                        input bit poke, input string tag);
    int len_eff = (len > BEATS) ? BEATS : len;
    int done_k  = -1;
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    int late    = 0;
    logic [31:0] exp_dot = '0;
    for (int i = 0; i < BEATS; i++) got[i] = 'x;
    for (int i = 0; i < len_eff; i++)
      for (int l = 0; l < LANES; l++)
        exp_dot += lane_model(2, 1'b0, a_mem[i][l*DW +: DW], b_mem[i][l*DW +: DW]);

    @(posedge clk); #1;
    start_i = 1'b1; mode_i = 2'(mode); sat_i = sat; len_i = LW'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      abort_i = (k == abort_k);
      if (poke && k == 2) begin
        start_i = 1'b1; mode_i = ~mode_i; sat_i = ~sat_i; len_i = 4'd1;
      end
      if (poke && k == 3) start_i = 1'b0;
      @(negedge clk);
      if (k == 1) check({tag, "_busy_k1"}, busy_o, 1);
      if (abort_k > 0 && k == abort_k + 1) check({tag, "_abort_idle"}, busy_o, 0);
      if (abort_k > 0 && k > abort_k) begin
        if (rd_en_o || wr_en_o || done_o) late++;
        if (k == abort_k + 12) break;
      end else begin
        if (rd_en_o) begin
          check({tag, "_rd_addr"}, rd_addr_o, rd_cnt);
          rd_cnt++;
        end
        if (wr_en_o) begin
          check({tag, "_wr_addr"}, wr_addr_o, k - 3);
          got[wr_addr_o] = wr_data_o;
          wr_cnt++;
        end
        if (done_o) begin
          done_k = k;
          if (mode == 3) check({tag, "_dot"}, dot_o, exp_dot);
          break;
        end
      end
      @(posedge clk); #1;
    end
    abort_i = 1'b0;
    start_i = 1'b0;

    if (abort_k > 0) begin
      check({tag, "_after_abort_activity"}, late, 0);
    end else begin
      check({tag, "_done_cycle"}, done_k, (len_eff == 0) ? 1 : len_eff + 3);
      check({tag, "_rd_count"}, rd_cnt, len_eff);
      check({tag, "_wr_count"}, wr_cnt, (mode == 3) ? 0 : len_eff);
      if (mode != 3)
        for (int i = 0; i < len_eff; i++)
          for (int l = 0; l < LANES; l++)
            check({tag, "_data"}, got[i][l*DW +: DW],
                  lane_model(mode, sat, a_mem[i][l*DW +: DW], b_mem[i][l*DW +: DW]));
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_idle_after_done"}, busy_o, 0);
    end
  endtask

  task automatic rst_in_drain();
    fill_const(32'd1000, 32'd7);
    @(posedge clk); #1;
    start_i = 1'b1; mode_i = 2'd0; sat_i = 1'b0; len_i = 4'd2;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_wr_en", wr_en_o, 1);
    check("rst_pre_wr_data", wr_data_o[31:0], 32'd1007);
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy", busy_o, 0);
    check("rst_async_wr_en", wr_en_o, 0);
    check("rst_async_wr_data", wr_data_o[31:0], 0);
    check("rst_async_wr_addr", wr_addr_o, 0);
    check("rst_async_rd_addr", rd_addr_o, 0);
    check("rst_async_done", done_o, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_wr_en", wr_en_o, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; sat_i = 1'b0; mode_i = 2'd0; len_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_rd_en", rd_en_o, 0);
    check("reset_wr_en", wr_en_o, 0);
    check("reset_wr_data", wr_data_o[63:0], 0);
    check("reset_dot", dot_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < BEATS; i++)
      for (int l = 0; l < LANES; l++) begin
        a_mem[i][l*DW +: DW] = 32'(i + 1);
        b_mem[i][l*DW +: DW] = 32'(10 * (i + 1));
      end
    run_op(0, 1'b0, 4, 0, 1'b0, "add4");
    for (int i = 0; i < 4; i++) check("add4_const", got[i][31:0], 32'(11 * (i + 1)));

    fill_const(32'h7FFF_FFF0, 32'h100);
    run_op(0, 1'b1, 1, 0, 1'b0, "add_sat");
    check("add_sat_const", got[0][31:0], 32'h7FFF_FFFF);
    run_op(0, 1'b0, 1, 0, 1'b0, "add_wrap");
    check("add_wrap_const", got[0][31:0], 32'h8000_00F0);

    fill_const(32'h8000_0010, 32'h100);
    run_op(1, 1'b1, 2, 0, 1'b0, "sub_sat");
    check("sub_sat_const", got[1][31:0], 32'h8000_0000);

    fill_const(32'd2, 32'd3);
    run_op(3, 1'b0, 2, 0, 1'b0, "dot2");
    check("dot2_held", dot_o, 48);

    run_op(0, 1'b0, 0, 0, 1'b0, "len0");
    fill_random();
    run_op(0, 1'b1, 12, 0, 1'b0, "len_clamp");

    fill_random();
    run_op(1, 1'b0, 8, 3, 1'b0, "abort");
    run_op(2, 1'b0, 8, 0, 1'b0, "post_abort");

    fill_random();
    run_op(0, 1'b1, 5, 0, 1'b1, "busy_start");

    rst_in_drain();
    fill_random();
    run_op(3, 1'b0, 3, 0, 1'b0, "post_rst");

    repeat (16) begin
      fill_random();
      run_op($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 10),
             ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
